// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master: register map, field positions,
// shifter states and reset defaults.
package sd_spi_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_DATA   = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;

    localparam int unsigned CTRL_CS_N    = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_DIV_LSB = 8;
    localparam int unsigned CTRL_LEN_LSB = 16;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_OVR  = 2;

    localparam logic [7:0] DIV_RESET = 8'h3F;
    localparam logic [4:0] LEN_RESET = 5'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_t;

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 bit engine: half-period timing, bit counting, MSB-first shift out
// and right-aligned capture of MISO.
module sd_spi_shifter
    import sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [4:0]  len,
    input  logic [7:0]  div,
    input  logic [31:0] tx,
    input  logic        miso,
    output logic        busy,
    output logic        done_pulse,
    output logic [31:0] rx,
    output logic        sck,
    output logic        mosi
);

    spi_state_t  state, state_d;
    logic [7:0]  cnt, div_q;
    logic [4:0]  bitcnt;
    logic [31:0] tx_q;
    logic        half_end, load, sample, step;

    assign half_end = (cnt == div_q);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d    = state;
        load       = 1'b0;
        sample     = 1'b0;
        step       = 1'b0;
        done_pulse = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_d = LOW;
                load    = 1'b1;
            end
            LOW: if (half_end) begin
                state_d = HIGH;
                sample  = 1'b1;
            end
            HIGH: if (half_end) begin
                if (bitcnt == 5'd0) begin
                    state_d    = IDLE;
                    done_pulse = 1'b1;
                end else begin
                    state_d = LOW;
                    step    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            div_q  <= '0;
            bitcnt <= '0;
            tx_q   <= '0;
            rx     <= '0;
            sck    <= 1'b0;
            mosi   <= 1'b1;
        end else if (load) begin
            div_q  <= div;
            bitcnt <= len;
            tx_q   <= tx;
            rx     <= '0;
            mosi   <= tx[len];
            cnt    <= '0;
        end else if (state != IDLE) begin
            cnt <= half_end ? 8'd0 : cnt + 8'd1;
            if (sample) begin
                rx  <= {rx[30:0], miso};
                sck <= 1'b1;
            end
            // falling edge of sck: next bit goes out here, never mid-half
            if (state == HIGH && half_end) begin
                sck <= 1'b0;
                if (step) begin
                    bitcnt <= bitcnt - 5'd1;
                    mosi   <= tx_q[bitcnt - 5'd1];
                end
            end
        end
    end

endmodule

// File: rtl/sd_spi_master.sv
// APB3 slave for the SD-card SPI link: register decode, CTRL, sticky status
// flags and interrupt around the bit engine.
module sd_spi_master
    import sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        irq
);

    logic        cs_n, irq_en, done, ovr;
    logic [7:0]  div;
    logic [4:0]  len;
    logic        wr, sel_ctrl, sel_data, sel_status;
    logic        start, busy, done_pulse;
    logic [31:0] rx, ctrl_rd, status_rd;
    logic        unused_addr;

    assign unused_addr = ^{paddr[7:4], paddr[1:0]};

    assign pready  = 1'b1;
    assign pslverr = 1'b0;

    assign wr         = psel & penable & pwrite;
    assign sel_ctrl   = (paddr[3:2] == OFF_CTRL[3:2]);
    assign sel_data   = (paddr[3:2] == OFF_DATA[3:2]);
    assign sel_status = (paddr[3:2] == OFF_STATUS[3:2]);
    assign start      = wr & sel_data & ~busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cs_n   <= 1'b1;
            irq_en <= 1'b0;
            div    <= DIV_RESET;
            len    <= LEN_RESET;
        end else if (wr && sel_ctrl) begin
            cs_n   <= pwdata[CTRL_CS_N];
            irq_en <= pwdata[CTRL_IRQ_EN];
            div    <= pwdata[CTRL_DIV_LSB +: 8];
            len    <= pwdata[CTRL_LEN_LSB +: 5];
        end
    end

    // set terms are ORed after the clear so a coincident set wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            done <= (done & ~(wr & sel_status & pwdata[STAT_DONE])) | done_pulse;
            ovr  <= (ovr & ~(wr & sel_status & pwdata[STAT_OVR])) | (wr & sel_data & busy);
        end
    end

    assign irq      = done & irq_en;
    assign spi_cs_n = cs_n;

    always_comb begin
        ctrl_rd                        = '0;
        ctrl_rd[CTRL_CS_N]             = cs_n;
        ctrl_rd[CTRL_IRQ_EN]           = irq_en;
        ctrl_rd[CTRL_DIV_LSB +: 8]     = div;
        ctrl_rd[CTRL_LEN_LSB +: 5]     = len;
        status_rd                      = '0;
        status_rd[STAT_BUSY]           = busy;
        status_rd[STAT_DONE]           = done;
        status_rd[STAT_OVR]            = ovr;
    end

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            if (sel_ctrl)        prdata = ctrl_rd;
            else if (sel_data)   prdata = rx;
            else if (sel_status) prdata = status_rd;
        end
    end

    sd_spi_shifter u_shifter (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .len        (len),
        .div        (div),
        .tx         (pwdata),
        .miso       (spi_miso),
        .busy       (busy),
        .done_pulse (done_pulse),
        .rx         (rx),
        .sck        (spi_sck),
        .mosi       (spi_mosi)
    );

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with a transfer scoreboard and SPI line monitors.
module tb_sd_spi_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        spi_sck, spi_mosi, spi_miso, spi_cs_n, irq;
    logic        loop, miso_fix;

    int tests = 0;
    int fails = 0;

    assign spi_miso = loop ? spi_mosi : miso_fix;

    always #5 clk = ~clk;

    sd_spi_master dut (
        .clk      (clk),
        .resetn   (resetn),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n),
        .irq      (irq)
    );

    int unsigned cyc = 0;
    int unsigned t_wr, t0, t_irq;
    int unsigned npulse, hi_run, hi_min, hi_max;
    logic [31:0] cap;
    logic        prev_sck = 1'b0;

    always @(posedge clk) cyc++;
    always @(posedge irq) t_irq = cyc;
    always @(posedge spi_sck) begin
        cap = {cap[30:0], spi_mosi};
        npulse++;
    end
    always @(negedge clk) begin
        if (spi_sck) hi_run++;
        else if (prev_sck) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
        end
        prev_sck = spi_sck;
    end

    typedef struct {
        logic [31:0] pat;
        logic [31:0] rx;
        int unsigned cycles;
        int unsigned n;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        #1;
        t_wr = cyc;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] data, input logic [31:0] exp_rx, input int unsigned n,
                              input int unsigned half);
        exp_t e;
        npulse = 0; cap = '0; hi_run = 0; hi_min = 32'hFFFF; hi_max = 0; t_irq = 0;
        apb_write(8'h04, data);
        t0 = t_wr;
        e.pat    = (n == 32) ? data : (data & ((32'd1 << n) - 32'd1));
        e.rx     = exp_rx;
        e.cycles = 2 * n * half;
        e.n      = n;
        sb.push_back(e);
    endtask

    task automatic finish_xfer(input string tag);
        exp_t e;
        logic [31:0] d;
        int k = 0;
        while (!irq && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_irq_seen"}, {31'd0, irq}, 32'd1);
        e = sb.pop_front();
        chk({tag, "_cycles"}, t_irq - t0, e.cycles);
        chk({tag, "_pulses"}, npulse, e.n);
        chk({tag, "_mosi_pattern"}, cap, e.pat);
        apb_read(8'h04, d);
        chk({tag, "_rx"}, d, e.rx);
    endtask

    logic [31:0] rd;

    initial begin
        resetn = 1'b0; loop = 1'b1; miso_fix = 1'b0;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        #12;
        chk("rst_sck", {31'd0, spi_sck}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_prdata_idle", prdata, 32'd0);
        chk("rst_pready_pslverr", {30'd0, pready, pslverr}, 32'd2);
        paddr = 8'h00; psel = 1'b1; #1;
        chk("rst_ctrl", prdata, 32'h00073F01);
        psel = 1'b0;
        @(negedge clk); resetn = 1'b1;

        // 8-bit loopback at full speed
        loop = 1'b1;
        apb_write(8'h00, 32'h00070002);
        chk("cs_low", {31'd0, spi_cs_n}, 32'd0);
        start_xfer(32'h000000A5, 32'h000000A5, 8, 1);
        finish_xfer("t1");
        chk("t1_hi_min", hi_min, 32'd1);
        chk("t1_hi_max", hi_max, 32'd1);
        apb_write(8'h08, 32'h6);
        chk("t1_irq_clr", {31'd0, irq}, 32'd0);

        // 32-bit, div 3, miso held high
        loop = 1'b0; miso_fix = 1'b1;
        apb_write(8'h00, 32'h001F0302);
        start_xfer(32'h12345678, 32'hFFFFFFFF, 32, 4);
        finish_xfer("t2");
        chk("t2_hi_min", hi_min, 32'd4);
        chk("t2_hi_max", hi_max, 32'd4);
        apb_write(8'h08, 32'h6);

        // DATA write while busy is dropped and flags ovr
        loop = 1'b1;
        apb_write(8'h00, 32'h00070002);
        start_xfer(32'h0000003C, 32'h0000003C, 8, 1);
        repeat (3) @(posedge clk);
        apb_write(8'h04, 32'h000000FF);
        chk("t3_ovr_edge", t_wr - t0, 32'd5);
        finish_xfer("t3");
        apb_read(8'h08, rd);
        chk("t3_status", rd, 32'h6);
        apb_write(8'h08, 32'h6);
        apb_read(8'h08, rd);
        chk("t3_status_clr", rd, 32'h0);

        // W1C on the same edge done sets: set wins
        apb_write(8'h00, 32'h00000002);
        start_xfer(32'h00000001, 32'h00000001, 1, 1);
        apb_write(8'h08, 32'h2);
        chk("t4_w1c_edge", t_wr - t0, 32'd2);
        chk("t4_irq_kept", {31'd0, irq}, 32'd1);
        apb_read(8'h08, rd);
        chk("t4_done_kept", rd, 32'h2);
        finish_xfer("t4");
        apb_write(8'h08, 32'h2);
        chk("t4_irq_cleared", {31'd0, irq}, 32'd0);
        apb_read(8'h08, rd);
        chk("t4_done_cleared", rd, 32'h0);

        // async reset while bit 3 is in its sck-high half
        apb_write(8'h00, 32'h00070302);
        apb_write(8'h04, 32'h00000000);
        repeat (29) @(negedge clk);
        chk("t5_pre_sck", {31'd0, spi_sck}, 32'd1);
        chk("t5_pre_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("t5_pre_cs_n", {31'd0, spi_cs_n}, 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("t5_rst_sck", {31'd0, spi_sck}, 32'd0);
        chk("t5_rst_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("t5_rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("t5_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); resetn = 1'b1;
        apb_read(8'h00, rd);
        chk("t5_ctrl", rd, 32'h00073F01);
        apb_read(8'h08, rd);
        chk("t5_status", rd, 32'h0);
        apb_read(8'h04, rd);
        chk("t5_rx", rd, 32'h0);
        apb_write(8'h00, 32'h00073F02);
        start_xfer(32'h000000C3, 32'h000000C3, 8, 64);
        finish_xfer("t6");
        chk("t6_hi_min", hi_min, 32'd64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

APB3 slave that sequences the SD-card SPI link: software sets chip-select, clock divider and transfer length, writes a data word, and the block shifts 1–32 bits MSB-first in SPI mode 0 while capturing MISO. It sits on the SoC's peripheral APB bridge next to the text-VRAM and GPIO slaves and drives the board's sd_clk, sd_cmd_mosi, sd_d0_miso and sd_d3_cs pins. It replaces software bit-banging of those pins.

## Interface
- DIV_RESET, 8'h3F: reset half-period divider; 25 MHz/(2·64) ≈ 195 kHz, within the SD init limit of ≤400 kHz.
- LEN_RESET, 5'd7: reset transfer length minus one, i.e. 8 bits.
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous assert, active-low.
- paddr  in  8  APB byte address; only [3:2] are decoded.
- psel, penable, pwrite  in  1  APB control.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data; combinational, valid in the access phase.
- pready  out  1  tied to 1 (zero wait states).
- pslverr  out  1  tied to 0.
- spi_sck  out  1  SPI clock; idle low.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in.
- spi_cs_n  out  1  chip select; software-controlled.
- irq  out  1  level interrupt: done AND irq_en.

## Operation
- A write happens in the cycle where psel & penable & pwrite are all 1; it takes effect at that rising edge. A read is side-effect free.
- Registers:
  - 0x00 CTRL: [0] cs_n, reset 1; [1] irq_en, reset 0; [15:8] div, reset DIV_RESET; [20:16] len, reset LEN_RESET.
  - 0x04 DATA. Write loads tx and starts a transfer of N = len+1 bits. Read returns rx.
  - 0x08 STATUS. [0] busy (read-only); [1] done (sticky, write-1-to-clear); [2] ovr (sticky, write-1-to-clear).
  - 0x0C reads 0.
- FSM states: IDLE, LOW, HIGH.
  - IDLE → LOW on a DATA write. At that point N and div are latched, bitcnt = N−1, rx is cleared, and mosi = tx[N−1].
  - LOW lasts div+1 cycles with sck = 0. On its last cycle, miso is shifted into rx at bit 0 (left shift), sck goes to 1, and the FSM enters HIGH.
  - HIGH lasts div+1 cycles with sck = 1. On its last cycle sck goes to 0.
    - If bitcnt = 0: go to IDLE and set done.
    - Otherwise: decrement bitcnt, set mosi = tx[bitcnt−1], and go to LOW.
- rx is right-aligned. After N bits, rx[N−1:0] holds the received bits, first bit at the MSB; the upper bits are 0.
- Writing DATA while busy: the write is ignored and ovr is set. The running transfer is unaffected.
- Writing CTRL while busy: cs_n and irq_en update immediately. div and len update in the register but apply only from the next transfer.
- done set and a W1C clear in the same cycle: set wins.
- Starting a transfer does not clear done; software clears it.
- mosi holds its last driven bit after the transfer; it is 1 out of reset.
- Reset mid-transfer forces all of the following at once, regardless of state:
  - FSM to IDLE;
  - sck = 0, mosi = 1, cs_n = 1;
  - rx = 0, busy, done and ovr = 0;
  - CTRL fields back to their reset values.

## Timing
- Output reset values: spi_sck 0, spi_mosi 1, spi_cs_n 1, irq 0, prdata 0 (no access), pready 1, pslverr 0.
- busy rises the cycle after the DATA write edge and falls on the cycle done rises.
- Transfer length: 2·N·(div+1) cycles from the write edge to done. Minimum is div = 0, N = 1: 2 cycles, giving a 12.5 MHz sck.
- mosi changes only on sck falling transitions, or at start. miso is sampled on the clk edge where sck rises.
- spi_miso is not synchronized. Board timing is closed for a half-period of at least 1 cycle.
- All SPI outputs are driven directly from flops; no combinational path from APB to the pins.

## Structure
- Package sd_spi_pkg holds:
  - the register offsets (0x00/0x04/0x08);
  - the CTRL/STATUS bit positions;
  - the state enum {IDLE, LOW, HIGH};
  - the DIV_RESET/LEN_RESET defaults.
- Sub-module sd_spi_shifter contains the FSM, the half-period counter, bitcnt, tx/rx and sck/mosi. Its interface is start/len/div/tx in and busy/done_pulse/rx out.
- The top level holds the APB decode, CTRL, sticky flags and irq.

## Test plan
- Reset: with resetn low, expect sck=0, mosi=1, cs_n=1, irq=0, CTRL reads 0x00073F01.
- CTRL=0x00070000 (div=0, len=7), DATA=0xA5, miso looped to mosi:
  - expect 8 sck pulses with pattern 1,0,1,0,0,1,0,1;
  - done after 16 cycles; rx=0x000000A5.
- CTRL div=3, len=31, DATA=0x12345678, miso tied 1:
  - expect 32 pulses, each half-period 4 cycles;
  - done after 256 cycles; rx=0xFFFFFFFF.
- DATA write at cycle 5 of a running 8-bit transfer:
  - expect ovr=1; the original tx is shifted unchanged; busy timing unchanged.
- irq_en=1 with a transfer completing: irq rises with done. W1C to STATUS[1] on the same cycle done sets: done stays 1. A later W1C clears done and irq.
- Assert resetn mid-transfer at bit 3: all outputs return to reset values immediately (async). After release, a new 8-bit transfer completes normally.
